// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring division on operand magnitudes, one quotient
// bit per cycle, truncate-toward-zero quotient and dividend-signed remainder.
module seq_signed_divider #(
  parameter int N = 16,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [N-1:0]    quotient_q;
  logic [M-1:0]    remainder_q;
  logic            dbz_q;
  logic            ovf_q;
  logic [N-1:0]    a_q;
  logic [M-1:0]    b_q;
  logic [M-1:0]    rem_q;
  logic [N-1:0]    q_mag_q;
  logic [CW-1:0]   cnt_q;
  logic            sign_q_q;
  logic            sign_r_q;
  logic            ovf_pend_q;

  logic [N-1:0]    a_abs_d;
  logic [M-1:0]    b_abs_d;
  logic [M:0]      rem_shift_d;
  logic            fits_d;
  logic [M-1:0]    rem_next_d;

  // -2^(N-1) negates to itself, which is exactly its unsigned magnitude
  assign a_abs_d     = dividend[N-1] ? -dividend : dividend;
  assign b_abs_d     = divisor[M-1]  ? -divisor  : divisor;
  assign rem_shift_d = {rem_q, a_q[N-1]};
  assign fits_d      = (rem_shift_d >= {1'b0, b_q});
  assign rem_next_d  = fits_d ? M'(rem_shift_d - {1'b0, b_q}) : rem_shift_d[M-1:0];

  // Control FSM and all datapath / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      q_mag_q     <= '0;
      cnt_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      ovf_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ready_q && in_valid) begin
            a_q        <= a_abs_d;
            b_q        <= b_abs_d;
            sign_q_q   <= dividend[N-1] ^ divisor[M-1];
            sign_r_q   <= dividend[N-1];
            rem_q      <= '0;
            q_mag_q    <= '0;
            cnt_q      <= CW'(N);
            ovf_pend_q <= (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == {M{1'b1}});
            in_ready_q <= 1'b0;
            if (divisor == {M{1'b0}}) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= {N{1'b1}};
              remainder_q <= dividend[M-1:0];
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
            end else begin
              state_q <= CALC;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          rem_q   <= rem_next_d;
          q_mag_q <= {q_mag_q[N-2:0], fits_d};
          a_q     <= {a_q[N-2:0], 1'b0};
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= FIX;
          end else begin
            state_q <= CALC;
          end
        end
        FIX: begin
          quotient_q  <= sign_q_q ? -q_mag_q : q_mag_q;
          remainder_q <= sign_r_q ? -rem_q : rem_q;
          ovf_q       <= ovf_pend_q;
          dbz_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Randomised and directed checks of seq_signed_divider against an integer-arithmetic model.
module tb_seq_signed_divider;

  localparam int N = 16;
  localparam int M = 8;
  localparam int LAT = N + 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int pass_cnt;
  int total_cnt;

  seq_signed_divider #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_div(input logic signed [N-1:0] a, input logic signed [M-1:0] b,
                                  output logic [N-1:0] q, output logic [M-1:0] r,
                                  output logic dz, output logic ov, output int lat);
    int ai;
    int bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 16'hFFFF; r = a[M-1:0]; dz = 1'b1; ov = 1'b0; lat = 0;
    end else if (ai == -32768 && bi == -1) begin
      q = 16'h8000; r = 8'h00; dz = 1'b0; ov = 1'b1; lat = LAT;
    end else begin
      q = 16'(ai / bi); r = 8'(ai % bi); dz = 1'b0; ov = 1'b0; lat = LAT;
    end
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b, input bit consume,
                        output logic [N-1:0] q, output logic [M-1:0] r,
                        output logic dz, output logic ov, output int lat);
    int k;
    lat = -1;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== '0)
      $display("FAIL reset_outputs: got rdy=%b ov=%b q=%h r=%h dz=%b of=%b, expected all 0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [10];
    logic [M-1:0] tb [10];
    logic [N-1:0] q, eq;
    logic [M-1:0] r, er;
    logic dz, edz, ov, eov;
    int lat, elat;
    ta = '{16'd100, -16'sd100, 16'd100, -16'sd100, -16'sd127, 16'h8000, 16'h8000, 16'd5, -16'sd5, 16'h7FFF};
    tb = '{8'd7, 8'd7, -8'sd7, -8'sd7, -8'sd1, 8'd1, 8'hFF, 8'd0, 8'h80, 8'h80};
    for (int i = 0; i < 10; i++) begin
      ref_div(ta[i], tb[i], eq, er, edz, eov, elat);
      run_op(ta[i], tb[i], 1'b1, q, r, dz, ov, lat);
      total_cnt++;
      if (q !== eq || r !== er || dz !== edz || ov !== eov)
        $display("FAIL directed_%0d (%0d/%0d): got q=%h r=%h dz=%b of=%b, expected q=%h r=%h dz=%b of=%b",
                 i, $signed(ta[i]), $signed(tb[i]), q, r, dz, ov, eq, er, edz, eov);
      else pass_cnt++;
      total_cnt++;
      if (lat !== elat)
        $display("FAIL directed_latency_%0d: got %0d, expected %0d", i, lat, elat);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] q, eq;
    logic [M-1:0] r, er;
    logic dz, edz, ov, eov;
    int lat, elat;
    ref_div(16'd1000, -8'sd9, eq, er, edz, eov, elat);
    run_op(16'd1000, -8'sd9, 1'b0, q, r, dz, ov, lat);
    total_cnt++;
    if (q !== eq || r !== er || lat !== elat)
      $display("FAIL bp_result: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=%0d", q, r, lat, eq, er, elat);
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      dividend = 16'd77; divisor = 8'd3; in_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq || remainder !== er)
        $display("FAIL bp_hold_%0d: got ov=%b rdy=%b q=%h r=%h, expected 1/0 q=%h r=%h",
                 c, out_valid, in_ready, quotient, remainder, eq, er);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== eq || remainder !== er)
      $display("FAIL bp_release: got ov=%b rdy=%b q=%h r=%h, expected 0/1 q=%h r=%h",
               out_valid, in_ready, quotient, remainder, eq, er);
    else pass_cnt++;
    ref_div(16'd50, 8'd3, eq, er, edz, eov, elat);
    run_op(16'd50, 8'd3, 1'b1, q, r, dz, ov, lat);
    total_cnt++;
    if (q !== eq || r !== er || lat !== elat)
      $display("FAIL bp_next_op: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=%0d", q, r, lat, eq, er, elat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic dz, ov;
    int lat;
    bit stale;
    dividend = 16'd25; divisor = 8'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== '0)
      $display("FAIL midreset_outputs: got rdy=%b ov=%b q=%h r=%h, expected all 0",
               in_ready, out_valid, quotient, remainder);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL midreset_ready: got %b, expected 1", in_ready);
    else pass_cnt++;
    stale = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if (stale)
      $display("FAIL midreset_stale: got out_valid=1 after reset, expected 0");
    else pass_cnt++;
    run_op(16'd25, 8'd5, 1'b1, q, r, dz, ov, lat);
    total_cnt++;
    if (q !== 16'd5 || r !== 8'd0 || lat !== LAT)
      $display("FAIL midreset_rerun: got q=%h r=%h lat=%0d, expected q=0005 r=00 lat=%0d", q, r, lat, LAT);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [N-1:0] a, q, eq;
    logic [M-1:0] b, r, er;
    logic dz, edz, ov, eov;
    int lat, elat, ai, bi, qi, ri;
    for (int i = 0; i < 200; i++) begin
      a = N'($urandom);
      b = M'($urandom);
      if (i % 25 == 3) b = 8'h00;
      if (i % 40 == 7) a = 16'h8000;
      if (i % 40 == 8) b = 8'h80;
      ref_div(a, b, eq, er, edz, eov, elat);
      run_op(a, b, 1'b1, q, r, dz, ov, lat);
      total_cnt++;
      if (q !== eq || r !== er || dz !== edz || ov !== eov || lat !== elat)
        $display("FAIL random_%0d (%0d/%0d): got q=%h r=%h dz=%b of=%b lat=%0d, expected q=%h r=%h dz=%b of=%b lat=%0d",
                 i, $signed(a), $signed(b), q, r, dz, ov, lat, eq, er, edz, eov, elat);
      else pass_cnt++;
      if (!edz && !eov) begin
        ai = $signed(a); bi = $signed(b); qi = $signed(q); ri = $signed(r);
        total_cnt++;
        if (ai != qi * bi + ri || (ri < 0 ? -ri : ri) >= (bi < 0 ? -bi : bi) ||
            (ri != 0 && ((ri < 0) != (ai < 0))))
          $display("FAIL random_identity_%0d: got q=%0d r=%0d, required a=%0d == q*b+r with b=%0d",
                   i, qi, ri, ai, bi);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
